// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback
// with a bounded wait on memory acknowledgements and a sticky error state.
module multicycle_control #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [5:0] op_i,
   input  logic       zero_i,
   input  logic       mem_ack_i,
   output logic       mem_req_o,
   output logic       mem_we_o,
   output logic       iord_o,
   output logic       irwrite_o,
   output logic       pcwrite_o,
   output logic       regwrite_o,
   output logic       regdst_o,
   output logic       memtoreg_o,
   output logic       alusrca_o,
   output logic [1:0] alusrcb_o,
   output logic [1:0] aluop_o,
   output logic [1:0] pcsrc_o,
   output logic [3:0] state_o,
   output logic       err_o
);

   localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      RWB    = 4'd8,
      IWB    = 4'd9,
      BRANCH = 4'd10,
      JUMP   = 4'd11,
      ERROR  = 4'd15
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       pcwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       err;
   } ctrl_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   ctrl_t         ctrl_q;
   logic          timeout;

   // Moore control word for the state being entered; EXEC needs the opcode
   // to pick between R-type and addi operand selects.
   function automatic ctrl_t moore_ctrl(input state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_req = 1'b1;
            c.alusrcb = 2'b01;
         end
         DECODE: c.alusrcb = 2'b11;
         MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         MEMRD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         MEMWR: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.iord    = 1'b1;
         end
         MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         EXEC: begin
            c.alusrca = 1'b1;
            if (op == OP_ADDI) c.alusrcb = 2'b10;
            else               c.aluop   = 2'b10;
         end
         RWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         IWB: c.regwrite = 1'b1;
         BRANCH: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b01;
            c.pcsrc   = 2'b01;
         end
         JUMP: begin
            c.pcsrc   = 2'b10;
            c.pcwrite = 1'b1;
         end
         ERROR:   c.err = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   assign timeout = (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (start_i) state_d = FETCH;
         FETCH: begin
            if (mem_ack_i)    state_d = DECODE;
            else if (timeout) state_d = ERROR;
            else              cnt_d   = cnt_q + CW'(1);
         end
         DECODE: begin
            case (op_i)
               OP_RTYPE, OP_ADDI: state_d = EXEC;
               OP_LW, OP_SW:      state_d = MEMADR;
               OP_BEQ:            state_d = BRANCH;
               OP_J:              state_d = JUMP;
               default:           state_d = ERROR;
            endcase
         end
         MEMADR: begin
            if (op_i == OP_LW)      state_d = MEMRD;
            else if (op_i == OP_SW) state_d = MEMWR;
            else                    state_d = ERROR;
         end
         MEMRD: begin
            if (mem_ack_i)    state_d = MEMWB;
            else if (timeout) state_d = ERROR;
            else              cnt_d   = cnt_q + CW'(1);
         end
         MEMWR: begin
            if (mem_ack_i)    state_d = start_i ? FETCH : IDLE;
            else if (timeout) state_d = ERROR;
            else              cnt_d   = cnt_q + CW'(1);
         end
         EXEC: begin
            if (op_i == OP_RTYPE)     state_d = RWB;
            else if (op_i == OP_ADDI) state_d = IWB;
            else                      state_d = ERROR;
         end
         MEMWB, RWB, IWB, BRANCH, JUMP: state_d = start_i ? FETCH : IDLE;
         ERROR:   state_d = ERROR;
         default: state_d = ERROR;
      endcase
      // Every entry into a request state starts a fresh wait window.
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep all state registers updating from the same pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= moore_ctrl(state_d, op_i);
      end
   end

   assign mem_req_o  = ctrl_q.mem_req;
   assign mem_we_o   = ctrl_q.mem_we;
   assign iord_o     = ctrl_q.iord;
   assign regwrite_o = ctrl_q.regwrite;
   assign regdst_o   = ctrl_q.regdst;
   assign memtoreg_o = ctrl_q.memtoreg;
   assign alusrca_o  = ctrl_q.alusrca;
   assign alusrcb_o  = ctrl_q.alusrcb;
   assign aluop_o    = ctrl_q.aluop;
   assign pcsrc_o    = ctrl_q.pcsrc;
   assign err_o      = ctrl_q.err;
   assign state_o    = state_q;

   // Mealy strobes: IR/PC latch on the fetch ack, branch PC write follows the ALU zero flag.
   assign irwrite_o = (state_q == FETCH) && mem_ack_i;
   assign pcwrite_o = ctrl_q.pcwrite | irwrite_o | ((state_q == BRANCH) && zero_i);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level expected-trace
// model builds per-cycle stimulus and expected outputs, one loop drives and compares.
module tb_multicycle_control;

   logic       clk_i, rst_i, start_i, zero_i, mem_ack_i;
   logic [5:0] op_i;
   logic       mem_req_o, mem_we_o, iord_o, irwrite_o, pcwrite_o, regwrite_o;
   logic       regdst_o, memtoreg_o, alusrca_o, err_o;
   logic [1:0] alusrcb_o, aluop_o, pcsrc_o;
   logic [3:0] state_o;
   logic [15:0] dut_outs;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;

   multicycle_control #(.ACK_TIMEOUT(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .zero_i(zero_i),
      .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
      .irwrite_o(irwrite_o), .pcwrite_o(pcwrite_o), .regwrite_o(regwrite_o),
      .regdst_o(regdst_o), .memtoreg_o(memtoreg_o), .alusrca_o(alusrca_o),
      .alusrcb_o(alusrcb_o), .aluop_o(aluop_o), .pcsrc_o(pcsrc_o), .state_o(state_o),
      .err_o(err_o)
   );

   assign dut_outs = {mem_req_o, mem_we_o, iord_o, irwrite_o, pcwrite_o, regwrite_o, regdst_o,
                      memtoreg_o, alusrca_o, alusrcb_o, aluop_o, pcsrc_o, err_o};

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        start;
      logic        zero;
      logic        ack;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [15:0] outs;
   } cyc_t;

   cyc_t plan[$];
   bit   noise = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input bit req, we, iord, irw, pcw, rw, rd, m2r, srca,
                                      input logic [1:0] srcb, aop, psrc, input bit err);
      return {req, we, iord, irw, pcw, rw, rd, m2r, srca, srcb, aop, psrc, err};
   endfunction

   // Cycles without a memory request get ack=noise, which the design must ignore.
   task automatic push(input int st, input logic [15:0] outs, input logic start,
                       input logic [5:0] op, input logic zero, input logic ack);
      cyc_t c;
      c.st = 4'(st); c.outs = outs; c.start = start; c.op = op; c.zero = zero;
      c.ack = outs[15] ? ack : noise;
      plan.push_back(c);
   endtask

   task automatic idle(input int n, input logic start);
      for (int k = 0; k < n; k++) push(0, 16'h0, start, 6'h0, 1'b0, 1'b0);
   endtask

   task automatic err_cycles(input int n);
      for (int k = 0; k < n; k++) push(15, mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), 1'b1, 6'h0, 1'b0, 1'b0);
   endtask

   // One instruction: fd/md = wait cycles before ack in fetch/memory, sm = start_i
   // during the instruction, se = start_i in its final cycle.
   task automatic instr(input logic [5:0] op, input int fd, input int md, input logic zero,
                        input logic sm, input logic se);
      for (int k = 0; k < fd; k++) push(1, mk(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), sm, op, zero, 1'b0);
      push(1, mk(1,0,0,1,1,0,0,0,0,2'b01,2'b00,2'b00,0), sm, op, zero, 1'b1);
      push(2, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), sm, op, zero, 1'b0);
      case (op)
         R: begin
            push(7, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), sm, op, zero, 1'b0);
            push(8, mk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0), se, op, zero, 1'b0);
         end
         ADDI: begin
            push(7, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), sm, op, zero, 1'b0);
            push(9, mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0), se, op, zero, 1'b0);
         end
         LW: begin
            push(3, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), sm, op, zero, 1'b0);
            for (int k = 0; k < md; k++) push(4, mk(1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), sm, op, zero, 1'b0);
            push(4, mk(1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), sm, op, zero, 1'b1);
            push(5, mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), se, op, zero, 1'b0);
         end
         SW: begin
            push(3, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), sm, op, zero, 1'b0);
            for (int k = 0; k < md; k++) push(6, mk(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), sm, op, zero, 1'b0);
            push(6, mk(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), se, op, zero, 1'b1);
         end
         BEQ: push(10, mk(0,0,0,0,zero,0,0,0,1,2'b00,2'b01,2'b01,0), se, op, zero, 1'b0);
         J:   push(11, mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b10,0), se, op, zero, 1'b0);
         default: push(15, mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), sm, op, zero, 1'b0);
      endcase
   endtask

   task automatic run_plan();
      cyc_t c;
      int   idx = 0;
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(posedge clk_i);
         #1;
         start_i = c.start; op_i = c.op; zero_i = c.zero; mem_ack_i = c.ack;
         @(negedge clk_i);
         check($sformatf("state@%0d", idx), 32'(state_o), 32'(c.st));
         check($sformatf("outs@%0d", idx), 32'(dut_outs), 32'(c.outs));
         idx++;
      end
   endtask

   initial begin
      int n0;
      rst_i = 1'b0; start_i = 1'b1; op_i = '0; zero_i = 1'b0; mem_ack_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check("reset_state", 32'(state_o), 32'd0);
      check("reset_outs", 32'(dut_outs), 32'd0);
      start_i = 1'b0; mem_ack_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;

      idle(2, 1'b0);
      idle(1, 1'b1);
      n0 = plan.size(); instr(R, 0, 0, 1'b0, 1'b1, 1'b1);    check("len_rtype", plan.size() - n0, 4);
      n0 = plan.size(); instr(ADDI, 0, 0, 1'b0, 1'b1, 1'b1); check("len_addi", plan.size() - n0, 4);
      noise = 1;
      n0 = plan.size(); instr(LW, 2, 2, 1'b0, 1'b1, 1'b1);   check("len_lw_wait2", plan.size() - n0, 9);
      noise = 0;
      n0 = plan.size(); instr(SW, 0, 0, 1'b0, 1'b1, 1'b1);   check("len_sw", plan.size() - n0, 4);
      n0 = plan.size(); instr(BEQ, 0, 0, 1'b1, 1'b1, 1'b1);  check("len_beq", plan.size() - n0, 3);
      instr(BEQ, 0, 0, 1'b0, 1'b1, 1'b1);
      n0 = plan.size(); instr(J, 0, 0, 1'b0, 1'b1, 1'b1);    check("len_j", plan.size() - n0, 3);
      noise = 1;
      instr(R, 1, 0, 1'b0, 1'b0, 1'b0);
      noise = 0;
      idle(2, 1'b0);
      idle(1, 1'b1);
      instr(ADDI, 15, 0, 1'b0, 1'b1, 1'b1);
      instr(BAD, 0, 0, 1'b0, 1'b1, 1'b1);
      noise = 1;
      err_cycles(2);
      noise = 0;
      run_plan();
      check("err_sticky", 32'(err_o), 32'd1);

      #2 rst_i = 1'b0;
      #1;
      check("err_reset_state", 32'(state_o), 32'd0);
      check("err_reset_err", 32'(err_o), 32'd0);
      start_i = 1'b0; mem_ack_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;

      // Fetch with no acknowledge for 16 request cycles.
      idle(1, 1'b1);
      for (int k = 0; k < 16; k++) push(1, mk(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, R, 1'b0, 1'b0);
      err_cycles(2);
      run_plan();
      check("timeout_err", 32'(err_o), 32'd1);

      #2 rst_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;

      // Store stalled in MEMWR, then reset between clock edges.
      idle(1, 1'b1);
      push(1, mk(1,0,0,1,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, SW, 1'b0, 1'b1);
      push(2, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), 1'b1, SW, 1'b0, 1'b0);
      push(3, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'b1, SW, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) push(6, mk(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, SW, 1'b0, 1'b0);
      run_plan();
      #2;
      check("memwr_req_before_reset", 32'(mem_req_o), 32'd1);
      rst_i = 1'b0;
      #1;
      check("async_reset_req", 32'(mem_req_o), 32'd0);
      check("async_reset_we", 32'(mem_we_o), 32'd0);
      check("async_reset_state", 32'(state_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: maximum number of cycles a memory request may wait for mem_ack_i.
REQ-002 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  run enable; sampled in IDLE and at each instruction boundary.
REQ-005 op_i  input  6  opcode (instruction bits 31:26) from the instruction register.
REQ-006 zero_i  input  1  ALU zero flag.
REQ-007 mem_ack_i  input  1  memory completion strobe; one cycle per completed access.
REQ-008 mem_req_o  output  1  memory request; held high until acknowledged.
REQ-009 mem_we_o  output  1  memory write (valid with mem_req_o).
REQ-010 iord_o  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 irwrite_o, pcwrite_o, regwrite_o  output  1 each  IR, PC and register-file write enables.
REQ-012 regdst_o, memtoreg_o, alusrca_o  output  1 each  register-file destination select, register-file data select and ALU A select (0 = PC, 1 = rs).
REQ-013 alusrcb_o  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-014 aluop_o  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-015 pcsrc_o  output  2  00 = ALU result, 01 = ALU output register, 10 = jump target.
REQ-016 state_o  output  4  current state encoding; err_o  output  1  sticky error flag.

Function
REQ-017 State encodings are IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, IWB=9, BRANCH=10, JUMP=11 and ERROR=15; codes 12-14 are unused.
REQ-018 All outputs are 0 in every state except where REQ-019 to REQ-030 assert them.
REQ-019 IDLE: the block moves to FETCH on start_i=1 and otherwise stays in IDLE.
REQ-020 FETCH: the block drives mem_req_o=1, iord_o=0, alusrca_o=0, alusrcb_o=01, aluop_o=00 and pcsrc_o=00.
REQ-021 FETCH: in the mem_ack_i cycle, irwrite_o=1 and pcwrite_o=1 (Mealy) and the next state is DECODE; otherwise the block stays in FETCH.
REQ-022 DECODE: the block drives alusrca_o=0, alusrcb_o=11 and aluop_o=00 (branch-target precompute).
REQ-023 DECODE next state by op_i: 000000 -> EXEC; 100011 (lw) and 101011 (sw) -> MEMADR; 001000 (addi) -> EXEC; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; any other opcode -> ERROR.
REQ-024 MEMADR: the block drives alusrca_o=1, alusrcb_o=10 and aluop_o=00; the next state is MEMRD for lw and MEMWR for sw.
REQ-025 MEMRD: the block drives mem_req_o=1 and iord_o=1, and moves to MEMWB on mem_ack_i.
REQ-026 MEMWR: the block drives mem_req_o=1, mem_we_o=1 and iord_o=1; on mem_ack_i the instruction ends (REQ-031).
REQ-027 MEMWB: the block drives regwrite_o=1, memtoreg_o=1 and regdst_o=0, then ends the instruction.
REQ-028 EXEC: the block drives alusrca_o=1; alusrcb_o=00 and aluop_o=10 for R-type, or alusrcb_o=10 and aluop_o=00 for addi.
REQ-029 EXEC next state: RWB for R-type, IWB for addi.
REQ-030 RWB: regwrite_o=1, regdst_o=1, memtoreg_o=0. IWB: regwrite_o=1, regdst_o=0, memtoreg_o=0. BRANCH: alusrca_o=1, alusrcb_o=00, aluop_o=01, pcsrc_o=01, pcwrite_o=zero_i (combinational). JUMP: pcsrc_o=10, pcwrite_o=1. After RWB, IWB, BRANCH and JUMP the instruction ends.
REQ-031 Instruction end: the next state is FETCH if start_i=1, otherwise IDLE.
REQ-032 Cycle counts with zero-wait memory (ack in the first request cycle): R-type/addi 4, beq/j 3, sw 4, lw 5.
REQ-033 Timeout counter: loads 0 on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_req_o=1 without mem_ack_i.
REQ-034 Timeout: when the counter reaches ACK_TIMEOUT-1 without ack, the next state is ERROR; an ack arriving in that same cycle takes priority and no error occurs.
REQ-035 ERROR: err_o=1 and all other outputs are 0; ERROR is left only by reset.
REQ-036 mem_ack_i received while mem_req_o=0 is ignored.
REQ-037 op_i is sampled only in DECODE and in EXEC/MEMADR.
REQ-038 start_i deasserting mid-instruction does not abort the instruction.

Reset
REQ-039 rst_i=0 immediately (asynchronously) forces state IDLE, counter 0, err_o=0 and all outputs 0, including during a pending memory request.
REQ-040 After rst_i rises, the first state change occurs no earlier than the next rising clk_i edge with start_i=1.

Verification
REQ-041 start_i=1, op_i=000000, immediate ack -> states 1,2,7,8,1; regwrite_o=1 and regdst_o=1 in RWB only.
REQ-042 lw with ack delayed 2 cycles in FETCH and MEMRD -> FETCH lasts 3 cycles, MEMRD 3 cycles, 9 cycles total; irwrite_o pulses exactly once.
REQ-043 beq with zero_i=1 -> pcwrite_o=1 and pcsrc_o=01 in BRANCH; with zero_i=0 -> pcwrite_o=0; both return to FETCH.
REQ-044 ACK_TIMEOUT=16 and no ack in FETCH -> ERROR entered after 16 request cycles with err_o=1; ack arriving in cycle 16 -> DECODE and no error.
REQ-045 op_i=111111 in DECODE -> ERROR with err_o=1; a later rst_i=0 pulse -> IDLE with err_o=0.
REQ-046 rst_i=0 in MEMWR mid-wait -> mem_req_o and mem_we_o drop without waiting for a clock edge; state_o=0.
